// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port pixel RAM between the capture writer
// and the VGA scan-out reader, both in the clk25 domain. Reads win every
// contested cycle; writes are posted into a small FIFO and drain into idle
// RAM slots.
// Optional feature macro: VRAM_STARVE_GUARD_EN (bounds consecutive read
// grants while writes are pending; undefined = reads have absolute priority).
module vram_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 6,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              fifo_flush,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [7:0]        drop_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(WFIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } gnt_state_e;

  // Saturating 8-bit increment for the drop counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

  logic [ADDR_W-1:0] fifo_addr_r [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;

  gnt_state_e        state_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              rd_p1_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              ovf_r;
  logic [7:0]        drop_cnt_r;

  logic              wr_ready_s;
  logic              fifo_empty_s;
  logic              force_wr_s;
  logic              grant_rd_s;
  logic              grant_wr_s;
  logic              push_s;
  logic              drop_s;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_C   = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);
  logic [STARVE_W-1:0] starve_cnt_r;
`endif

  // wr_ready depends on count only; a same-cycle pop does not raise it
  assign wr_ready_s = (count_r < DEPTH_C);
  assign wr_ready   = wr_ready_s;
  assign rd_gnt     = grant_rd_s;

  // Grant arbitration and FIFO push/drop qualification
  always_comb begin
    fifo_empty_s = (count_r == {(PTR_W+1){1'b0}});
    force_wr_s   = 1'b0;
`ifdef VRAM_STARVE_GUARD_EN
    if ((starve_cnt_r >= STARVE_C) && !fifo_empty_s && !fifo_flush) begin
      force_wr_s = 1'b1;
    end else begin
      force_wr_s = 1'b0;
    end
`endif
    grant_rd_s = rd_req && !force_wr_s;
    grant_wr_s = !grant_rd_s && !fifo_empty_s && !fifo_flush;
    push_s     = wr_req && wr_ready_s && !fifo_flush;
    drop_s     = wr_req && !wr_ready_s && !fifo_flush;
  end

`ifdef VRAM_STARVE_GUARD_EN
  // Count consecutive read grants taken while writes wait
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else if (grant_wr_s || fifo_flush || fifo_empty_s) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else if (grant_rd_s && (starve_cnt_r < STARVE_C)) begin
      starve_cnt_r <= starve_cnt_r + STARVE_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Posted-write FIFO storage, pointers and occupancy
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= {DATA_W{1'b0}};
      end
    end else if (fifo_flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= wr_addr;
        fifo_data_r[wr_ptr_r] <= wr_data;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (grant_wr_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, grant_wr_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Grant state and registered RAM port
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      case ({grant_rd_s, grant_wr_s})
        2'b10: begin
          state_r    <= ST_RD;
          mem_en_r   <= 1'b1;
          mem_we_r   <= 1'b0;
          mem_addr_r <= rd_addr;
        end
        2'b01: begin
          state_r     <= ST_WR;
          mem_en_r    <= 1'b1;
          mem_we_r    <= 1'b1;
          mem_addr_r  <= fifo_addr_r[rd_ptr_r];
          mem_wdata_r <= fifo_data_r[rd_ptr_r];
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipeline: RAM data lands one edge after the access edge
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_r    <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      rd_p1_r    <= (state_r == ST_RD);
      rd_valid_r <= rd_p1_r;
      if (rd_p1_r) begin
        rd_data_r <= mem_rdata;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      ovf_r      <= 1'b1;
      drop_cnt_r <= ovf_clr ? 8'd1 : sat_inc8(drop_cnt_r);
    end else if (ovf_clr) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      ovf_r      <= ovf_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign ovf       = ovf_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port pixel RAM between two requesters: the Gigatron capture writer and the VGA scan-out reader.
- Both requesters are already in the clk25 domain.
- Reads win every contested cycle, because the display has a hard deadline. Writes are posted into a small FIFO and drain into idle RAM slots.
- Sits between the capture logic, the 640x480 timing generator, and the RAM macro. This replaces the per-register pixel arrays.

Parameters:
ADDR_W, 15, pixel address width (160x120 = 19200 pixels)
DATA_W, 6, pixel width (RGB 2:2:2)
WFIFO_DEPTH, 4, posted-write FIFO entries (power of two, at least 2)
STARVE_LIMIT, 8, consecutive read grants allowed while writes are pending (used only with the optional feature)

Ports:
clk25  in  1  system clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  capture write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
wr_ready  out  1  FIFO can accept a write this cycle
rd_req  in  1  display read request
rd_addr  in  ADDR_W  read address
rd_gnt  out  1  read accepted this cycle
rd_data  out  DATA_W  read pixel
rd_valid  out  1  rd_data valid strobe
fifo_flush  in  1  synchronous discard of all pending writes
ovf  out  1  sticky: a write was presented while wr_ready was low
ovf_clr  in  1  synchronous clear of ovf and drop_cnt
drop_cnt  out  8  saturating count of dropped writes
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one clock after a read access

Behaviour:
- Reset (rst_n low, async): FIFO empty, wr_ready=1, rd_gnt=0, rd_valid=0, rd_data=0, ovf=0, drop_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, grant state=IDLE.
- Reset mid-operation aborts everything: pending writes are lost, and in-flight reads produce no rd_valid.
- wr_ready = (count < WFIFO_DEPTH). It is combinational from count only, so a pop in the same cycle does not raise it.
- Push happens when wr_req and wr_ready. When wr_req and !wr_ready: the write is dropped, ovf is set, and drop_cnt increments, saturating at 255.
- Grant state is one of IDLE, RD or WR, re-evaluated every edge, in this priority order:
  - rd_req high: go to RD.
  - else FIFO non-empty: go to WR and pop the head.
  - else: go to IDLE.
- rd_gnt is combinational and equals rd_req (but see the optional feature).
- Memory outputs are registered.
  - RD: mem_en=1, mem_we=0, mem_addr=rd_addr.
  - WR: mem_en=1, mem_we=1, mem_addr and mem_wdata taken from the FIFO head.
  - IDLE: mem_en=0, mem_we=0, mem_addr and mem_wdata hold their values.
- Read latency is fixed:
  - rd_req is granted at edge k.
  - mem_rdata is valid after edge k+1.
  - rd_data is registered and rd_valid=1 after edge k+2, for exactly one cycle per grant.
  - Back-to-back reads give one rd_valid per cycle, in order.
- Push and pop in the same cycle leave count unchanged.
- Pop on an empty FIFO cannot occur.
- A push to a full FIFO is a drop, even when a pop happens in the same cycle.
- Write ordering is preserved (FIFO order).
- Read-after-write hazard: if a pending FIFO write targets the address being read, the read returns the old RAM content. This is accepted; the display tolerates one-frame staleness.
- fifo_flush empties the FIFO at the edge and blocks any WR grant that cycle; a simultaneous push is discarded and not counted as a drop. Reads are unaffected.
- ovf_clr clears ovf and drop_cnt. A simultaneous drop wins: ovf=1, drop_cnt=1.
- FIFO pointers are log2(WFIFO_DEPTH) bits wide and wrap naturally; count is log2(WFIFO_DEPTH)+1 bits.

Optional Feature:
VRAM_STARVE_GUARD_EN
- Defined:
  - A counter tracks consecutive RD grants made while the FIFO is non-empty.
  - When the counter reaches STARVE_LIMIT, the next cycle grants WR even if rd_req is high. In that cycle rd_gnt=0, and the reader must hold its request.
  - The counter resets on any WR grant, and whenever the FIFO is empty.
- Undefined: reads have absolute priority, rd_gnt == rd_req, and writes can starve indefinitely.

Test Plan:
- Reset release, then 3 writes (addr 0x10/0x11/0x12, data 0x3F/0x2A/0x15) with no reads: mem_we pulses on 3 consecutive cycles in order, and wr_ready stays 1.
- Read addr 0x0100 with RAM preloaded 0x21: mem_en=1, mem_we=0 after edge k, and rd_valid=1 with rd_data=0x21 after edge k+2.
- rd_req held high for 20 cycles while 6 writes are offered (depth 4): 4 accepted, wr_ready falls, 2 dropped, ovf=1, drop_cnt=2. The 4 writes drain after rd_req falls.
- wr_req and fifo_flush in the same cycle with 2 entries pending: count becomes 0, no mem_we follows, and drop_cnt is unchanged.
- Drop and ovf_clr in the same cycle: ovf=1 and drop_cnt=1. With drop_cnt at 255, another drop leaves it at 255.
- With VRAM_STARVE_GUARD_EN, STARVE_LIMIT=8, rd_req held high and 1 write pending: a WR grant occurs on cycle 9 with rd_gnt=0 that cycle. Without the macro, no write occurs while rd_req is high.
